// File: rtl/chunked_adder_if.sv
// chunked_adder_if: start/done bus between a requester and chunked_adder.
// Ports: master drives start, A, B, C_in, sub; slave returns busy, done, S, C_out, V.
// WIDTH must match the WIDTH of the adder it is connected to.
interface chunked_adder_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             C_in;
    logic             sub;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] S;
    logic             C_out;
    logic             V;

    modport master (
        output start, A, B, C_in, sub,
        input  busy, done, S, C_out, V
    );

    modport slave (
        input  start, A, B, C_in, sub,
        output busy, done, S, C_out, V
    );
endinterface

// File: rtl/chunked_adder.sv
// chunked_adder: multi-cycle add/subtract, CHUNK bits per cycle, LS chunk first.
// Latency: N = WIDTH/CHUNK cycles from the accepting edge to done; one op per N+1 cycles.
// Backpressure: start is only sampled in IDLE/DONE; it is ignored while busy.
// Ports: clk, reset (async active-high), bus (chunked_adder_if.slave):
//   start/A/B/C_in/sub in, busy/done/S/C_out/V out (all registered).
module chunked_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic            clk,
    input  logic            reset,
    chunked_adder_if.slave  bus
);
    localparam int N  = WIDTH / CHUNK;
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] opa_q;
    logic [WIDTH-1:0] opb_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] s_q;
    logic [IW-1:0]    idx_q;
    logic             carry_q;
    logic             cout_q;
    logic             v_q;
    logic             busy_q;
    logic             done_q;

    // One CHUNK-bit slice of the datapath, selected by the chunk index.
    logic [CHUNK-1:0] a_ch;
    logic [CHUNK-1:0] b_ch;
    logic [CHUNK-1:0] sum_ch;
    logic             c_ch;
    logic             c_msb_in;
    logic             last;
    logic [WIDTH-1:0] acc_d;

    always_comb begin
        a_ch     = opa_q[int'(idx_q)*CHUNK +: CHUNK];
        b_ch     = opb_q[int'(idx_q)*CHUNK +: CHUNK];
        {c_ch, sum_ch} = {1'b0, a_ch} + {1'b0, b_ch} + {{CHUNK{1'b0}}, carry_q};
        // Carry into the chunk MSB recovered from the MSB sum bit: s = a ^ b ^ cin.
        c_msb_in = a_ch[CHUNK-1] ^ b_ch[CHUNK-1] ^ sum_ch[CHUNK-1];
        last     = (idx_q == IW'(N - 1));
        acc_d    = acc_q;
        acc_d[int'(idx_q)*CHUNK +: CHUNK] = sum_ch;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            opa_q   <= '0;
            opb_q   <= '0;
            acc_q   <= '0;
            s_q     <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            v_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        opa_q   <= bus.A;
                        // Subtract as A + ~B + ~borrow_in.
                        opb_q   <= bus.sub ? ~bus.B : bus.B;
                        carry_q <= bus.C_in ^ bus.sub;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                RUN: begin
                    acc_q   <= acc_d;
                    carry_q <= c_ch;
                    idx_q   <= idx_q + IW'(1);
                    if (last) begin
                        s_q     <= acc_d;
                        cout_q  <= c_ch;
                        v_q     <= c_msb_in ^ c_ch;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.S     = s_q;
    assign bus.C_out = cout_q;
    assign bus.V     = v_q;
endmodule

// File: tb/tb_chunked_adder.sv
// Directed bench for chunked_adder: 16/4 instance plus 4/1 and 4/4 sweeps.
// Inputs are driven and outputs sampled 1 time unit after the rising edge.
module tb_chunked_adder;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    chunked_adder_if #(.WIDTH(16)) b16 ();
    chunked_adder_if #(.WIDTH(4))  b4s ();
    chunked_adder_if #(.WIDTH(4))  b4w ();

    chunked_adder #(.WIDTH(16), .CHUNK(4)) dut16 (.clk(clk), .reset(reset), .bus(b16));
    chunked_adder #(.WIDTH(4),  .CHUNK(1)) dut4s (.clk(clk), .reset(reset), .bus(b4s));
    chunked_adder #(.WIDTH(4),  .CHUNK(4)) dut4w (.clk(clk), .reset(reset), .bus(b4w));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic launch16(input logic [15:0] a, input logic [15:0] b,
                            input logic cin, input logic sb);
        b16.A = a; b16.B = b; b16.C_in = cin; b16.sub = sb; b16.start = 1'b1;
        @(posedge clk); #1;
        b16.start = 1'b0;
    endtask

    task automatic wait16(output int lat);
        lat = 0;
        while (b16.done !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic op16(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic cin, input logic sb,
                        input logic [15:0] es, input logic ec, input logic ev);
        int lat;
        launch16(a, b, cin, sb);
        chk({tag, " busy_run"}, 32'(b16.busy), 32'd1);
        wait16(lat);
        chk({tag, " latency"}, 32'(lat), 32'd4);
        chk({tag, " busy_done"}, 32'(b16.busy), 32'd0);
        chk({tag, " S"}, 32'(b16.S), 32'(es));
        chk({tag, " C_out"}, 32'(b16.C_out), 32'(ec));
        chk({tag, " V"}, 32'(b16.V), 32'(ev));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int d0;
        int seen;
        logic [3:0] a4;
        logic [3:0] b4;
        logic       c4;
        logic [4:0] e5;

        reset = 1'b1;
        b16.start = 1'b0; b16.A = '0; b16.B = '0; b16.C_in = 1'b0; b16.sub = 1'b0;
        b4s.start = 1'b0; b4s.A = '0; b4s.B = '0; b4s.C_in = 1'b0; b4s.sub = 1'b0;
        b4w.start = 1'b0; b4w.A = '0; b4w.B = '0; b4w.C_in = 1'b0; b4w.sub = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state and quiet idle before the first start.
        chk("rst busy", 32'(b16.busy), 32'd0);
        chk("rst done", 32'(b16.done), 32'd0);
        chk("rst S", 32'(b16.S), 32'd0);
        chk("rst C_out", 32'(b16.C_out), 32'd0);
        chk("rst V", 32'(b16.V), 32'd0);
        repeat (2) begin @(posedge clk); #1; end
        chk("idle done", 32'(b16.done), 32'd0);
        chk("idle busy", 32'(b16.busy), 32'd0);

        // Basic add, then done must be a single-cycle pulse and results hold.
        op16("add", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
        @(posedge clk); #1;
        chk("pulse done", 32'(b16.done), 32'd0);
        chk("hold S", 32'(b16.S), 32'h5555);

        // Full-width carry and signed overflow.
        op16("carry", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        op16("ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);

        // Subtract.
        op16("sub1", 16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0);
        op16("sub2", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        op16("sub3", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        op16("subb", 16'h0010, 16'h0001, 1'b1, 1'b1, 16'h000E, 1'b1, 1'b0);

        // Start pulses during RUN cycles 1 and 2 are ignored.
        @(posedge clk); #1;
        launch16(16'h1111, 16'h2222, 1'b0, 1'b0);
        b16.A = 16'hFFFF; b16.B = 16'hFFFF; b16.sub = 1'b1; b16.start = 1'b1;
        @(posedge clk); #1;
        b16.A = 16'h0F0F; b16.C_in = 1'b1;
        @(posedge clk); #1;
        b16.start = 1'b0;
        wait16(lat);
        chk("hs latency", 32'(lat), 32'd2);
        chk("hs S", 32'(b16.S), 32'h3333);
        chk("hs C_out", 32'(b16.C_out), 32'd0);
        chk("hs V", 32'(b16.V), 32'd0);

        // Start in the DONE cycle is accepted: next done 5 cycles later.
        d0 = cyc;
        launch16(16'h8000, 16'h8000, 1'b1, 1'b0);
        wait16(lat);
        chk("b2b spacing", 32'(cyc - d0), 32'd5);
        chk("b2b S", 32'(b16.S), 32'h0001);
        chk("b2b C_out", 32'(b16.C_out), 32'd1);
        chk("b2b V", 32'(b16.V), 32'd1);

        // Asynchronous reset two cycles into RUN.
        @(posedge clk); #1;
        launch16(16'hAAAA, 16'h5555, 1'b0, 1'b0);
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        chk("mid busy", 32'(b16.busy), 32'd0);
        chk("mid S", 32'(b16.S), 32'd0);
        chk("mid C_out", 32'(b16.C_out), 32'd0);
        chk("mid V", 32'(b16.V), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        seen = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (b16.done === 1'b1) seen++;
        end
        chk("mid no_done", 32'(seen), 32'd0);
        op16("post", 16'hABCD, 16'h1111, 1'b0, 1'b0, 16'hBCDE, 1'b0, 1'b0);

        // WIDTH=4 sweeps: CHUNK=1 (latency 4) and CHUNK=4 (latency 1).
        for (int i = 0; i < 8; i++) begin
            a4 = 4'(i); b4 = 4'(i + 4); c4 = 1'(i % 2);
            e5 = 5'(i + (i + 4) + (i % 2));
            b4s.A = a4; b4s.B = b4; b4s.C_in = c4; b4s.sub = 1'b0; b4s.start = 1'b1;
            @(posedge clk); #1;
            b4s.start = 1'b0;
            lat = 0;
            while (b4s.done !== 1'b1 && lat < 20) begin @(posedge clk); #1; lat++; end
            chk($sformatf("c1 lat %0d", i), 32'(lat), 32'd4);
            chk($sformatf("c1 sum %0d", i), 32'({b4s.C_out, b4s.S}), 32'(e5));
        end
        for (int i = 0; i < 8; i++) begin
            a4 = 4'(i); b4 = 4'(i + 4); c4 = 1'(i % 2);
            e5 = 5'(i + (i + 4) + (i % 2));
            b4w.A = a4; b4w.B = b4; b4w.C_in = c4; b4w.sub = 1'b0; b4w.start = 1'b1;
            @(posedge clk); #1;
            b4w.start = 1'b0;
            lat = 0;
            while (b4w.done !== 1'b1 && lat < 20) begin @(posedge clk); #1; lat++; end
            chk($sformatf("c4 lat %0d", i), 32'(lat), 32'd1);
            chk($sformatf("c4 sum %0d", i), 32'({b4w.C_out, b4w.S}), 32'(e5));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
